// File: rtl/pwm8_pkg.sv
// Shared types and helpers for the pwm8 duty-cycle decoder.
package pwm8_pkg;

   localparam int unsigned DefWidth      = 8;
   localparam int unsigned DefSyncStages = 2;

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow
   } pwm8_state_e;

   // Increment that sticks at max instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
      return (val == max) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/pwm8_sync.sv
// Input synchroniser for pwm8_decode, with a 3-sample majority glitch filter when
// PWM8_DECODE_FILTER_EN is defined.
module pwm8_sync
   import pwm8_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic s_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef PWM8_DECODE_FILTER_EN
   // Two older samples plus the current one; costs one cycle of latency.
   logic [1:0] filt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         filt_q <= '0;
      end else begin
         filt_q <= {filt_q[0], sync_last};
      end
   end

   assign s_o = (sync_last & filt_q[0]) | (sync_last & filt_q[1]) | (filt_q[0] & filt_q[1]);
`else
   assign s_o = sync_last;
`endif

endmodule

// File: rtl/pwm8_decode.sv
// PWM duty-cycle decoder: measures high time once per period, flags wrong periods and
// constant-level input. Optional glitch filter enabled by PWM8_DECODE_FILTER_EN.
module pwm8_decode
   import pwm8_pkg::*;
#(
   parameter int unsigned WIDTH       = DefWidth,
   parameter int unsigned SYNC_STAGES = DefSyncStages
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] duty,
   output logic             valid,
   output logic             period_err,
   output logic             stuck
);

   localparam int unsigned     CW      = WIDTH + 1;
   localparam logic [CW-1:0]   Period  = {1'b1, {WIDTH{1'b0}}};
   localparam logic [CW-1:0]   CntMax  = '1;
   localparam logic [WIDTH-1:0] DutyMax = '1;

   logic        s, s_q;
   logic        rise, fall, edge_det, timeout;
   logic [CW-1:0] hi_q, lo_q, idle_q;
   logic [CW-1:0] hi_inc, lo_inc, per;
   pwm8_state_e state_q;

   logic [WIDTH-1:0] duty_q;
   logic             valid_q, err_q, stuck_q;

   pwm8_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i(clk),
      .rst_i(rst),
      .d_i  (pwm_in),
      .s_o  (s)
   );

   assign rise     = s & ~s_q;
   assign fall     = ~s & s_q;
   assign edge_det = rise | fall;

   always_comb begin
      hi_inc  = CW'(sat_inc(32'(hi_q), 32'(CntMax)));
      lo_inc  = CW'(sat_inc(32'(lo_q), 32'(CntMax)));
      // The closing rise cycle is the last low cycle, so count it in the period.
      per     = hi_q + lo_inc;
      // An edge restarts the idle count, so a same-cycle rise always beats the timeout.
      timeout = !edge_det && (idle_q == Period - 1'b1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= 1'b0;
         state_q <= StIdle;
         hi_q    <= '0;
         lo_q    <= '0;
         idle_q  <= '0;
         duty_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         s_q     <= s;
         valid_q <= 1'b0;
         idle_q  <= edge_det ? '0 : idle_q + 1'b1;
         if (timeout) begin
            valid_q <= 1'b1;
            duty_q  <= s ? DutyMax : '0;
            err_q   <= 1'b0;
            stuck_q <= 1'b1;
            idle_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            state_q <= StIdle;
         end else begin
            case (state_q)
               StIdle: begin
                  if (rise) begin
                     hi_q    <= '0;
                     lo_q    <= '0;
                     state_q <= StHigh;
                  end
               end
               StHigh: begin
                  hi_q <= hi_inc;
                  if (fall) begin
                     state_q <= StLow;
                  end
               end
               StLow: begin
                  if (rise) begin
                     valid_q <= 1'b1;
                     duty_q  <= hi_q[WIDTH] ? DutyMax : hi_q[WIDTH-1:0];
                     err_q   <= (per != Period);
                     stuck_q <= 1'b0;
                     hi_q    <= '0;
                     lo_q    <= '0;
                     state_q <= StHigh;
                  end else begin
                     lo_q <= lo_inc;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign duty       = duty_q;
   assign valid      = valid_q;
   assign period_err = err_q;
   assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm8_decode.sv
// Randomised self-checking bench for pwm8_decode against an edge-timestamp reference model.
module tb_pwm8_decode;

   localparam int NS = 2;
   localparam int P  = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pwm_in = 1'b0;
   logic [7:0] duty;
   logic       valid, period_err, stuck;

   int    n_vec = 0;
   int    n_err = 0;
   string phase = "reset";

   always #5 clk = ~clk;

   pwm8_decode #(
      .WIDTH      (8),
      .SYNC_STAGES(NS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (pwm_in),
      .duty      (duty),
      .valid     (valid),
      .period_err(period_err),
      .stuck     (stuck)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the decoder seen as timestamps of edges on the delayed input.
   logic [NS+1:0] line = '0;
   logic          ms_q = 1'b0;
   logic          armed = 1'b0, seen_fall = 1'b0;
   int            t = 0, rise_t = 0, fall_t = 0, last_edge = 0;
   logic          exp_valid = 1'b0, exp_err = 1'b0, exp_stuck = 1'b0;
   logic [7:0]    exp_duty = 8'h00;

   function automatic logic model_s(input logic [NS+1:0] ln);
`ifdef PWM8_DECODE_FILTER_EN
      return (ln[NS-1] & ln[NS]) | (ln[NS-1] & ln[NS+1]) | (ln[NS] & ln[NS+1]);
`else
      return ln[NS-1];
`endif
   endfunction

   task automatic model_step();
      logic cur;
      int   hi_len;
      if (rst) begin
         line      = '0;
         ms_q      = 1'b0;
         armed     = 1'b0;
         seen_fall = 1'b0;
         last_edge = t;
         exp_valid = 1'b0;
         exp_duty  = 8'h00;
         exp_err   = 1'b0;
         exp_stuck = 1'b0;
      end else begin
         cur       = model_s(line);
         exp_valid = 1'b0;
         if (cur && !ms_q) begin
            if (armed && seen_fall) begin
               hi_len    = fall_t - rise_t;
               exp_valid = 1'b1;
               exp_duty  = (hi_len > 255) ? 8'hFF : 8'(hi_len);
               exp_err   = ((t - rise_t) != P);
               exp_stuck = 1'b0;
            end
            armed     = 1'b1;
            seen_fall = 1'b0;
            rise_t    = t;
            last_edge = t;
         end else if (!cur && ms_q) begin
            if (armed) begin
               seen_fall = 1'b1;
               fall_t    = t;
            end
            last_edge = t;
         end else if (t - last_edge == P) begin
            exp_valid = 1'b1;
            exp_duty  = cur ? 8'hFF : 8'h00;
            exp_err   = 1'b0;
            exp_stuck = 1'b1;
            armed     = 1'b0;
            seen_fall = 1'b0;
            last_edge = t;
         end
         ms_q = cur;
         line = {line[NS:0], pwm_in};
      end
      t++;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check_val({phase, ".valid"}, 32'(valid), 32'(exp_valid));
         check_val({phase, ".report"}, 32'({period_err, stuck, duty}),
                   32'({exp_err, exp_stuck, exp_duty}));
      end
   end

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int d_tab[4];
      int h, l;
      d_tab[0] = 1;
      d_tab[1] = 8'h80;
      d_tab[2] = 8'hFE;
      d_tab[3] = 8'hFF;

      rst = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      phase = "steady_aa";
      repeat (6) begin
         hold(1'b1, 170);
         hold(1'b0, 86);
      end

      phase = "sweep";
      foreach (d_tab[i]) begin
         repeat (3) begin
            hold(1'b1, d_tab[i]);
            hold(1'b0, P - d_tab[i]);
         end
      end

      phase = "stuck";
      hold(1'b0, 1000);
      hold(1'b1, 1000);

      phase = "bad_period";
      repeat (4) begin
         hold(1'b1, 100);
         hold(1'b0, 100);
      end
      repeat (4) begin
         hold(1'b1, 256);
         hold(1'b0, 44);
      end
      repeat (3) begin
         hold(1'b1, 280);
         hold(1'b0, 20);
      end

      phase = "reset_mid_high";
      hold(1'b1, 50);
      rst = 1'b1;
      hold(1'b1, 1);
      rst = 1'b0;
      hold(1'b1, 50);
      hold(1'b0, 100);
      repeat (3) begin
         hold(1'b1, 8'h90);
         hold(1'b0, P - 8'h90);
      end

      phase = "glitch";
      repeat (3) begin
         hold(1'b1, 8'h40);
         hold(1'b0, 100);
         hold(1'b1, 1);
         hold(1'b0, 91);
      end

      phase = "random";
      repeat (40) begin
         h = $urandom_range(1, 255);
         if ($urandom_range(0, 1) == 0) begin
            l = P - h;
         end else begin
            l = $urandom_range(1, 300);
         end
         hold(1'b1, h);
         hold(1'b0, l);
      end
      hold(1'b1, 1);
      hold(1'b0, 20);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
